// File: rtl/board_io_ctrl_if.sv
// rtl/board_io_ctrl_if.sv - signal bundle between host logic (master) and board_io_ctrl (slave)
interface board_io_ctrl_if #(
  parameter int N_SW     = 16,
  parameter int N_BTN    = 4,
  parameter int N_LED    = 16,
  parameter int N_DIGITS = 4
);
  logic [N_SW-1:0]       sw_in;
  logic [N_BTN-1:0]      btn_in;
  logic [N_SW-1:0]       sw;
  logic [N_BTN-1:0]      btn;
  logic [N_BTN-1:0]      btn_press;
  logic [N_LED-1:0]      led_value;
  logic [N_LED-1:0]      led;
  logic [4*N_DIGITS-1:0] seg_value;
  logic [N_DIGITS-1:0]   dp_value;
  logic [N_DIGITS-1:0]   digit_en;
  logic [6:0]            seg;
  logic                  dp;
  logic [N_DIGITS-1:0]   an;
  logic [N_BTN-1:0]      irq_mask;
  logic [N_BTN-1:0]      irq_clr;
  logic [N_BTN-1:0]      irq_pending;
  logic                  irq;

  modport master (
    output sw_in, btn_in, led_value, seg_value, dp_value, digit_en, irq_mask, irq_clr,
    input  sw, btn, btn_press, led, seg, dp, an, irq_pending, irq
  );

  modport slave (
    input  sw_in, btn_in, led_value, seg_value, dp_value, digit_en, irq_mask, irq_clr,
    output sw, btn, btn_press, led, seg, dp, an, irq_pending, irq
  );
endinterface

// File: rtl/board_io_ctrl.sv
// rtl/board_io_ctrl.sv - switch sync, button debounce, LED register, 7-seg scan, optional irq
// Optional button-event interrupt logic is enabled by defining BOARD_IO_IRQ_EN.
module board_io_ctrl #(
  parameter int N_SW            = 16,
  parameter int N_BTN           = 4,
  parameter int N_LED           = 16,
  parameter int N_DIGITS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SCAN_CYCLES     = 100000
) (
  input  logic             clk,
  input  logic             rst,
  board_io_ctrl_if.slave   io
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int PRE_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [N_SW-1:0]     sw_meta, sw_sync;
  logic [N_BTN-1:0]    btn_meta, btn_sync;
  logic [N_BTN-1:0]    btn_q, press_q;
  logic [CNT_W-1:0]    cnt [N_BTN];
  logic [N_LED-1:0]    led_q;
  logic [PRE_W-1:0]    pre;
  logic [IDX_W-1:0]    idx;
  logic [6:0]          seg_q;
  logic                dp_q;
  logic [N_DIGITS-1:0] an_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= '0;
      btn_sync <= '0;
      led_q    <= '0;
    end else begin
      sw_meta  <= io.sw_in;
      sw_sync  <= sw_meta;
      btn_meta <= io.btn_in;
      btn_sync <= btn_meta;
      led_q    <= io.led_value;
    end
  end

  // Counter runs only while the synchronized input disagrees with the accepted level.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q   <= '0;
      press_q <= '0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        press_q[i] <= 1'b0;
        if (btn_sync[i] == btn_q[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i]     <= '0;
          btn_q[i]   <= btn_sync[i];
          press_q[i] <= btn_sync[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PRE_LAST) begin
      pre <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  logic [3:0]          nib;
  logic                en_cur;
  logic [6:0]          hex_seg;
  logic [N_DIGITS-1:0] an_next;

  // Decode is combinational from live inputs so value changes show up on the next edge.
  always_comb begin
    nib     = io.seg_value[idx*4 +: 4];
    en_cur  = io.digit_en[idx];
    an_next = '1;
    if (en_cur) an_next[idx] = 1'b0;
    case (nib)
      4'h0:    hex_seg = 7'b1000000;
      4'h1:    hex_seg = 7'b1111001;
      4'h2:    hex_seg = 7'b0100100;
      4'h3:    hex_seg = 7'b0110000;
      4'h4:    hex_seg = 7'b0011001;
      4'h5:    hex_seg = 7'b0010010;
      4'h6:    hex_seg = 7'b0000010;
      4'h7:    hex_seg = 7'b1111000;
      4'h8:    hex_seg = 7'b0000000;
      4'h9:    hex_seg = 7'b0010000;
      4'hA:    hex_seg = 7'b0001000;
      4'hB:    hex_seg = 7'b0000011;
      4'hC:    hex_seg = 7'b1000110;
      4'hD:    hex_seg = 7'b0100001;
      4'hE:    hex_seg = 7'b0000110;
      default: hex_seg = 7'b0001110;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= '1;
      dp_q  <= 1'b1;
      an_q  <= '1;
    end else begin
      an_q  <= an_next;
      seg_q <= en_cur ? hex_seg : 7'h7F;
      dp_q  <= en_cur ? ~io.dp_value[idx] : 1'b1;
    end
  end

  assign io.sw        = sw_sync;
  assign io.btn       = btn_q;
  assign io.btn_press = press_q;
  assign io.led       = led_q;
  assign io.seg       = seg_q;
  assign io.dp        = dp_q;
  assign io.an        = an_q;

`ifdef BOARD_IO_IRQ_EN
  logic [N_BTN-1:0] pend_q;
  logic             irq_q;

  // OR-ing the press in after the clear makes a new event win over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= (pend_q & ~io.irq_clr) | press_q;
      irq_q  <= |(pend_q & io.irq_mask);
    end
  end

  assign io.irq_pending = pend_q;
  assign io.irq         = irq_q;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{io.irq_mask, io.irq_clr};
  assign io.irq_pending    = '0;
  assign io.irq            = 1'b0;
`endif
endmodule

// File: tb/tb_board_io_ctrl.sv
// tb/tb_board_io_ctrl.sv - self-checking bench for board_io_ctrl (optionally with BOARD_IO_IRQ_EN)
module tb_board_io_ctrl;
  localparam int N_SW = 16, N_BTN = 4, N_LED = 16, N_DIGITS = 4;
  localparam int DEB = 8, SCAN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  board_io_ctrl_if #(.N_SW(N_SW), .N_BTN(N_BTN), .N_LED(N_LED), .N_DIGITS(N_DIGITS)) io ();

  board_io_ctrl #(
    .N_SW(N_SW), .N_BTN(N_BTN), .N_LED(N_LED), .N_DIGITS(N_DIGITS),
    .DEBOUNCE_CYCLES(DEB), .SCAN_CYCLES(SCAN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io(io)
  );

  // Lit segments per hex digit; every other segment stays high (off).
  string lit [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                      "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  typedef struct {
    logic [3:0] nib;
    logic       dpv;
    logic       en;
    logic [6:0] exp_seg;
    logic       exp_dp;
  } vec_t;
  vec_t vecs [18];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] nib);
    logic [6:0] m;
    m = 7'h7F;
    for (int k = 0; k < lit[nib].len(); k++) m[lit[nib][k] - 8'd97] = 1'b0;
    return m;
  endfunction

  // Output after the k-th edge out of reset shows digit ((k-1)/SCAN) mod N_DIGITS.
  task automatic check_disp(input string tag);
    int         d;
    logic [3:0] an_e;
    logic [6:0] seg_e;
    logic       dp_e;
    d     = ((cyc - 1) / SCAN) % N_DIGITS;
    an_e  = 4'hF;
    seg_e = 7'h7F;
    dp_e  = 1'b1;
    if (io.digit_en[d]) begin
      an_e[d] = 1'b0;
      seg_e   = seg_of(io.seg_value[d*4 +: 4]);
      dp_e    = ~io.dp_value[d];
    end
    check({tag, "_an"}, io.an, an_e);
    check({tag, "_seg"}, io.seg, seg_e);
    check({tag, "_dp"}, io.dp, dp_e);
  endtask

  task automatic wait_press(input int b, input string tag, output int first_btn, output int n_press,
                            output int press_at);
    first_btn = -1;
    n_press   = 0;
    press_at  = -1;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (io.btn[b] && first_btn < 0) first_btn = j;
      if (io.btn_press[b]) begin
        n_press++;
        if (press_at < 0) press_at = j;
      end
    end
    check({tag, "_btn_at"}, first_btn, DEB + 2);
    check({tag, "_press_at"}, press_at, DEB + 2);
    check({tag, "_press_cnt"}, n_press, 1);
  endtask

  logic [3:0]  hist [0:400];
  logic [15:0] prev_sw;
  logic [3:0]  btn_m, press_m, an_low;
  int          fb, np, pa, bad;

  initial begin
    vecs[0]  = '{4'h0, 1'b0, 1'b1, 7'b1000000, 1'b1};
    vecs[1]  = '{4'h1, 1'b1, 1'b1, 7'b1111001, 1'b0};
    vecs[2]  = '{4'h2, 1'b0, 1'b1, 7'b0100100, 1'b1};
    vecs[3]  = '{4'h3, 1'b1, 1'b1, 7'b0110000, 1'b0};
    vecs[4]  = '{4'h4, 1'b0, 1'b1, 7'b0011001, 1'b1};
    vecs[5]  = '{4'h5, 1'b1, 1'b1, 7'b0010010, 1'b0};
    vecs[6]  = '{4'h6, 1'b0, 1'b1, 7'b0000010, 1'b1};
    vecs[7]  = '{4'h7, 1'b1, 1'b1, 7'b1111000, 1'b0};
    vecs[8]  = '{4'h8, 1'b0, 1'b1, 7'b0000000, 1'b1};
    vecs[9]  = '{4'h9, 1'b1, 1'b1, 7'b0010000, 1'b0};
    vecs[10] = '{4'hA, 1'b0, 1'b1, 7'b0001000, 1'b1};
    vecs[11] = '{4'hB, 1'b1, 1'b1, 7'b0000011, 1'b0};
    vecs[12] = '{4'hC, 1'b0, 1'b1, 7'b1000110, 1'b1};
    vecs[13] = '{4'hD, 1'b1, 1'b1, 7'b0100001, 1'b0};
    vecs[14] = '{4'hE, 1'b0, 1'b1, 7'b0000110, 1'b1};
    vecs[15] = '{4'hF, 1'b1, 1'b1, 7'b0001110, 1'b0};
    vecs[16] = '{4'h8, 1'b1, 1'b0, 7'b1111111, 1'b1};
    vecs[17] = '{4'h3, 1'b0, 1'b0, 7'b1111111, 1'b1};

    io.sw_in = '0; io.btn_in = '0; io.led_value = '0; io.seg_value = '0;
    io.dp_value = '0; io.digit_en = '0; io.irq_mask = '0; io.irq_clr = '0;
    rst = 1'b1;
    io.led_value = 16'hFFFF;
    io.sw_in     = 16'hFFFF;
    io.digit_en  = 4'hF;
    repeat (5) step();
    check("rst_sw", io.sw, 0);
    check("rst_btn", io.btn, 0);
    check("rst_press", io.btn_press, 0);
    check("rst_led", io.led, 0);
    check("rst_seg", io.seg, 7'h7F);
    check("rst_dp", io.dp, 1);
    check("rst_an", io.an, 4'hF);
    check("rst_pend", io.irq_pending, 0);
    check("rst_irq", io.irq, 0);
    io.sw_in = '0;
    io.led_value = '0;
    rst = 1'b0;

    // Static decode table: every digit carries the same nibble, so the scan slot is irrelevant.
    for (int v = 0; v < 18; v++) begin
      io.seg_value = {4{vecs[v].nib}};
      io.dp_value  = {4{vecs[v].dpv}};
      io.digit_en  = {4{vecs[v].en}};
      step();
      check($sformatf("tbl_seg[%0d]", v), io.seg, vecs[v].exp_seg);
      check($sformatf("tbl_dp[%0d]", v), io.dp, vecs[v].exp_dp);
    end

    io.seg_value = 16'hA5F3; io.digit_en = 4'b1111; io.dp_value = 4'b0100;
    for (int j = 0; j < 32; j++) begin
      step();
      check_disp("scan_all");
    end

    io.digit_en = 4'b0101;
    an_low = '0;
    for (int j = 0; j < 32; j++) begin
      step();
      check_disp("scan_blank");
      an_low = an_low | ~io.an;
    end
    check("blank_an_never_low", an_low & 4'b1010, 0);

    prev_sw = io.sw_in;
    for (int j = 0; j < 200; j++) begin
      io.sw_in     = 16'($urandom);
      io.led_value = 16'($urandom);
      io.seg_value = 16'($urandom);
      io.dp_value  = 4'($urandom);
      io.digit_en  = 4'($urandom);
      io.irq_mask  = 4'($urandom);
      io.irq_clr   = 4'($urandom);
      step();
      check("rand_sw", io.sw, prev_sw);
      check("rand_led", io.led, io.led_value);
      check_disp("rand");
      check("rand_pend", io.irq_pending, 0);
      check("rand_irq", io.irq, 0);
      prev_sw = io.sw_in;
    end
    io.irq_mask = '0; io.irq_clr = '0;

    io.btn_in[0] = 1'b1;
    wait_press(0, "press0", fb, np, pa);
    io.btn_in[0] = 1'b0;
    bad = 0;
    for (int j = 0; j < 12; j++) begin
      step();
      if (io.btn_press[0]) bad++;
    end
    check("release0_btn", io.btn[0], 0);
    check("release0_no_press", bad, 0);

    io.btn_in[1] = 1'b1;
    repeat (5) step();
    io.btn_in[1] = 1'b0;
    bad = 0;
    for (int j = 0; j < 20; j++) begin
      step();
      if (io.btn[1] || io.btn_press[1]) bad++;
    end
    check("glitch1_ignored", bad, 0);

    io.btn_in[2] = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      check("midrst_an", io.an, 4'hF);
      check("midrst_btn", io.btn, 0);
    end
    rst = 1'b0;
    wait_press(2, "afterrst2", fb, np, pa);
    io.btn_in[2] = 1'b0;
    repeat (12) step();

`ifdef BOARD_IO_IRQ_EN
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    io.irq_mask = 4'b0001;
    io.btn_in[0] = 1'b1;
    pa = -1;
    for (int j = 0; j < 20 && pa < 0; j++) begin
      step();
      if (io.btn_press[0]) pa = j;
    end
    check("irq_press_seen", pa >= 0, 1);
    step();
    check("irq_pend_set", io.irq_pending, 4'b0001);
    step();
    check("irq_asserted", io.irq, 1);
    io.irq_clr = 4'b0001;
    step();
    io.irq_clr = '0;
    check("irq_pend_cleared", io.irq_pending, 0);
    step();
    check("irq_deasserted", io.irq, 0);
    io.btn_in[0] = 1'b0;
    repeat (12) step();
    io.btn_in[0] = 1'b1;
    pa = -1;
    for (int j = 0; j < 20 && pa < 0; j++) begin
      step();
      if (io.btn_press[0]) pa = j;
    end
    check("irq_press2_seen", pa >= 0, 1);
    io.irq_clr = 4'b0001;
    step();
    io.irq_clr = '0;
    check("irq_set_beats_clr", io.irq_pending[0], 1);
    io.btn_in[0] = 1'b0;
    io.irq_mask  = '0;
    repeat (12) step();
`else
    io.irq_mask = 4'hF;
    io.btn_in[3] = 1'b1;
    bad = 0;
    for (int j = 0; j < 20; j++) begin
      io.irq_clr = 4'($urandom);
      step();
      if (io.irq_pending != 0 || io.irq != 0) bad++;
    end
    check("noirq_tied_low", bad, 0);
    check("noirq_btn3_taken", io.btn[3], 1);
    io.btn_in[3] = 1'b0;
    io.irq_mask = '0;
    io.irq_clr  = '0;
    repeat (12) step();
`endif

    // Random buttons: a level is accepted once the last DEB synchronized samples all oppose it.
    io.btn_in = '0;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    for (int k = 0; k <= 10; k++) hist[k] = '0;
    btn_m = '0;
    for (int j = 1; j <= 300; j++) begin
      for (int i = 0; i < N_BTN; i++)
        if ($urandom_range(0, 5) == 0) io.btn_in[i] = ~io.btn_in[i];
      hist[j + 10] = io.btn_in;
      step();
      press_m = '0;
      for (int i = 0; i < N_BTN; i++) begin
        bad = 0;
        for (int k = 2; k <= DEB + 1; k++)
          if (hist[j + 10 - k][i] == btn_m[i]) bad = 1;
        if (bad == 0) begin
          btn_m[i]   = ~btn_m[i];
          press_m[i] = btn_m[i];
        end
      end
      check("rbtn_level", io.btn, btn_m);
      check("rbtn_press", io.btn_press, press_m);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/board_io_ctrl.md
BOARD_IO_CTRL -- requirements
Module: board_io_ctrl

Interface
REQ-001 SHALL have parameter N_SW, default 16, number of slide switches.
REQ-002 SHALL have parameter N_BTN, default 4, number of debounced push buttons.
REQ-003 SHALL have parameter N_LED, default 16, number of LEDs.
REQ-004 SHALL have parameter N_DIGITS, default 4, number of 7-segment digits; legal range 1..8.
REQ-005 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable-input cycles before a button change is accepted; minimum 2.
REQ-006 SHALL have parameter SCAN_CYCLES, default 100000, cycles each digit is driven; minimum 1.
REQ-007 SHALL have ports: clk  in  1  system clock; rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have ports: sw_in  in  N_SW  raw switches (asynchronous); btn_in  in  N_BTN  raw buttons (asynchronous).
REQ-009 SHALL have ports: sw  out  N_SW  synchronized switches; btn  out  N_BTN  debounced button level; btn_press  out  N_BTN  one-cycle rising-edge pulse.
REQ-010 SHALL have ports: led_value  in  N_LED  requested LED state; led  out  N_LED  registered LED drive.
REQ-011 SHALL have ports: seg_value  in  4*N_DIGITS  hex nibble per digit, digit 0 in bits 3:0; dp_value  in  N_DIGITS  decimal point per digit (1 = lit); digit_en  in  N_DIGITS  digit enable (1 = shown).
REQ-012 SHALL have ports: seg  out  7  segments a..g in bits 0..6, active-low; dp  out  1  active-low; an  out  N_DIGITS  anodes, active-low.
REQ-013 SHALL have ports: irq_mask  in  N_BTN  event interrupt enable; irq_clr  in  N_BTN  pending-clear pulses; irq_pending  out  N_BTN; irq  out  1.

Function
REQ-014 SHALL pass sw_in and btn_in each through a two-flop synchronizer; sw equals sw_in delayed exactly 2 cycles.
REQ-015 SHALL keep per-button counter: synchronized value equal to btn -> counter cleared; differs -> counter increments.
REQ-016 SHALL update btn[i] to the synchronized value, and clear the counter, in the cycle the counter reaches DEBOUNCE_CYCLES-1; a glitch shorter than DEBOUNCE_CYCLES cycles never changes btn.
REQ-017 SHALL assert btn_press[i] for exactly one cycle, coincident with the first cycle btn[i] is 1; no pulse on release.
REQ-018 SHALL register led from led_value with 1-cycle latency.
REQ-019 SHALL run a prescaler 0..SCAN_CYCLES-1; on wrap, digit index advances by 1, wrapping N_DIGITS-1 -> 0.
REQ-020 SHALL register seg, dp, an each cycle from the current index: an = all ones except bit index low when digit_en[index]=1; seg = active-low hex decode (0-9, A, b, C, d, E, F) of nibble index; dp = ~dp_value[index].
REQ-021 SHALL drive seg and dp all ones while digit_en[index]=0 (blanked digit).
REQ-022 SHALL reflect changes on seg_value/dp_value/digit_en at the outputs within 1 cycle, without waiting for the next scan step.

Reset
REQ-023 SHALL on rst clear synchronizers, debounce counters, btn, btn_press, sw, led, prescaler, index and irq_pending to 0, and set seg, dp, an to all ones.
REQ-024 SHALL, when rst is asserted mid-debounce, discard the partial count; a held button is re-accepted DEBOUNCE_CYCLES+2 cycles after rst deasserts and produces btn_press.

Configuration
REQ-025 SHALL, with BOARD_IO_IRQ_EN defined, set irq_pending[i] on btn_press[i], clear it on irq_clr[i], with set winning over simultaneous clear; irq = |(irq_pending & irq_mask), registered.
REQ-026 SHALL, with BOARD_IO_IRQ_EN undefined, tie irq_pending and irq to 0 and ignore irq_mask and irq_clr.

Verification (DEBOUNCE_CYCLES=8, SCAN_CYCLES=4, N_DIGITS=4, N_BTN=4)
REQ-027 SHALL cover: btn_in[0] 0->1 held -> btn[0]=1 and btn_press[0]=1 for one cycle, 10 cycles after the edge.
REQ-028 SHALL cover: btn_in[1] high for 5 cycles then low -> btn[1] stays 0, no btn_press.
REQ-029 SHALL cover: seg_value=16'hA5F3, digit_en=4'b1111, dp_value=4'b0100 -> an cycles 1110,1101,1011,0111 every 4 cycles; seg=0110000 (3), 0001110 (F), 0010010 (5), 0001000 (A); dp low only with an=1011.
REQ-030 SHALL cover: digit_en=4'b0101 -> an bits 1 and 3 never low; seg=dp=all ones during those slots.
REQ-031 SHALL cover: BOARD_IO_IRQ_EN defined, irq_mask=4'b0001, press btn 0 -> irq_pending[0]=1 and irq=1 next cycle; irq_clr[0] asserted in the same cycle as a new btn_press[0] -> pending remains 1.
REQ-032 SHALL cover: rst asserted 4 cycles into a debounce with button held -> btn stays 0 until 10 cycles after rst release; an=1111 during reset.
